// File: rtl/mem_arbiter_if.sv
// CPU/DMA request-grant-response channels plus the shared memory bus of mem_arbiter.
// slave = the arbiter's view; master = requesters and memory model.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic [20:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;

    logic [20:0] mem_addr;
    logic [7:0]  mem_dIn;
    logic [7:0]  mem_dOut;
    logic        mem_re;
    logic        mem_we;
    logic        mem_CE_n;
    logic        mem_CER_n;
    logic        busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_dIn, mem_re, mem_we, mem_CE_n, mem_CER_n, busy,
        input  mem_dOut
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_dIn, mem_re, mem_we, mem_CE_n, mem_CER_n, busy,
        output mem_dOut
    );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA single-port memory arbiter; ARB_ROUNDROBIN_EN selects round-robin over fixed CPU priority.
// gnt+strobe 1 cycle after req sampled, rvalid 3 (+IO_WAIT) cycles; loser simply keeps req high until IDLE.
module mem_arbiter #(
    parameter int IO_WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [20:0] RAM_BASE = 21'h1F0000;
    localparam logic [20:0] RAM_END  = 21'h1F8000;
    localparam logic [20:0] IO_BASE  = 21'h1FE000;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic        owner_q, owner_d;          // 1 = DMA owns the current access
    logic        we_q, we_d;
    logic [20:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
    logic        cpu_rvalid_q, cpu_rvalid_d, dma_rvalid_q, dma_rvalid_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic        grant_dma;
    logic [20:0] win_addr;

`ifdef ARB_ROUNDROBIN_EN
    logic ptr_q, ptr_d;                     // 1 = DMA wins the next tie
    assign grant_dma = bus.dma_req && (!bus.cpu_req || ptr_q);
`else
    assign grant_dma = bus.dma_req && !bus.cpu_req;
`endif
    assign win_addr = grant_dma ? bus.dma_addr : bus.cpu_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_q       <= 2'd0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 21'd0;
            wdata_q      <= 8'd0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 8'd0;
            dma_rdata_q  <= 8'd0;
`ifdef ARB_ROUNDROBIN_EN
            ptr_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dma_gnt_q    <= dma_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
`ifdef ARB_ROUNDROBIN_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_gnt_d    = 1'b0;
        dma_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dma_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
`ifdef ARB_ROUNDROBIN_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    state_d   = ACCESS;
                    owner_d   = grant_dma;
                    we_d      = grant_dma ? bus.dma_we : bus.cpu_we;
                    addr_d    = win_addr;
                    wdata_d   = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
                    wait_d    = (win_addr >= IO_BASE) ? 2'(IO_WAIT) : 2'd0;
                    cpu_gnt_d = !grant_dma;
                    dma_gnt_d = grant_dma;
`ifdef ARB_ROUNDROBIN_EN
                    ptr_d     = !grant_dma;
`endif
                end
            end
            ACCESS: begin
                if (wait_q != 2'd0) begin
                    wait_d = wait_q - 2'd1;
                end else begin
                    state_d = we_q ? IDLE : RESP;
                end
            end
            RESP: begin
                // memory has registered mem_dOut by now; publish it to the owner
                state_d = IDLE;
                if (owner_q) begin
                    dma_rdata_d  = bus.mem_dOut;
                    dma_rvalid_d = 1'b1;
                end else begin
                    cpu_rdata_d  = bus.mem_dOut;
                    cpu_rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.mem_re     = (state_q == ACCESS) && !we_q;
        bus.mem_we     = (state_q == ACCESS) && we_q;
        bus.mem_CE_n   = !((state_q == ACCESS) && (addr_q < RAM_BASE));
        bus.mem_CER_n  = !((state_q == ACCESS) && (addr_q >= RAM_BASE) && (addr_q < RAM_END));
        bus.mem_addr   = addr_q;
        bus.mem_dIn    = wdata_q;
        bus.cpu_gnt    = cpu_gnt_q;
        bus.dma_gnt    = dma_gnt_q;
        bus.cpu_rvalid = cpu_rvalid_q;
        bus.dma_rvalid = dma_rvalid_q;
        bus.cpu_rdata  = cpu_rdata_q;
        bus.dma_rdata  = dma_rdata_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector table plus hand sequences for arbitration, back-to-back timing and reset abort.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] mem_q = 8'h00;
    int checks = 0;
    int errors = 0;
    logic [7:0] sh_cpu = 8'h00;
    logic [7:0] sh_dma = 8'h00;

    mem_arbiter_if ifc ();

    mem_arbiter #(.IO_WAIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // memory model: read data registered one cycle after mem_re
    always @(posedge clk) if (ifc.mem_re) mem_q <= rd_val;
    assign ifc.mem_dOut = mem_q;

    typedef struct {
        bit          dma;
        bit          we;
        logic [20:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdv;
        int          strobes;
        bit          ce_n;
        bit          cer_n;
        int          rv_k;
        int          busy_n;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int gnt_k = 0, gnt_n = 0, other = 0, strobe_n = 0, bad_type = 0;
        int ce_bad = 0, addr_bad = 0, rv_k = 0, rv_n = 0, busy_n = 0;
        logic [7:0] got = 8'h00;
        logic own_gnt, own_rv;
        @(negedge clk);
        rd_val = v.rdv;
        if (v.dma) begin
            ifc.dma_req = 1'b1; ifc.dma_we = v.we; ifc.dma_addr = v.addr; ifc.dma_wdata = v.wdata;
        end else begin
            ifc.cpu_req = 1'b1; ifc.cpu_we = v.we; ifc.cpu_addr = v.addr; ifc.cpu_wdata = v.wdata;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            own_gnt = v.dma ? ifc.dma_gnt : ifc.cpu_gnt;
            own_rv  = v.dma ? ifc.dma_rvalid : ifc.cpu_rvalid;
            if (own_gnt) begin
                gnt_n++;
                if (gnt_k == 0) gnt_k = k;
                ifc.cpu_req = 1'b0;
                ifc.dma_req = 1'b0;
            end
            if (v.dma ? (ifc.cpu_gnt || ifc.cpu_rvalid) : (ifc.dma_gnt || ifc.dma_rvalid)) other++;
            if (ifc.mem_re || ifc.mem_we) begin
                strobe_n++;
                if (ifc.mem_re == v.we || ifc.mem_we != v.we) bad_type++;
                if (ifc.mem_CE_n != v.ce_n || ifc.mem_CER_n != v.cer_n) ce_bad++;
                if (ifc.mem_addr != v.addr || (v.we && ifc.mem_dIn != v.wdata)) addr_bad++;
            end else if (!ifc.mem_CE_n || !ifc.mem_CER_n) begin
                ce_bad++;
            end
            if (own_rv) begin
                rv_n++;
                rv_k = k;
                got = v.dma ? ifc.dma_rdata : ifc.cpu_rdata;
            end
            if (ifc.busy) busy_n++;
        end
        check($sformatf("v%0d_gnt_cycle", idx), gnt_k, 1);
        check($sformatf("v%0d_gnt_count", idx), gnt_n, 1);
        check($sformatf("v%0d_strobes", idx), strobe_n, v.strobes);
        check($sformatf("v%0d_strobe_type", idx), bad_type, 0);
        check($sformatf("v%0d_chip_enables", idx), ce_bad, 0);
        check($sformatf("v%0d_addr_data_stable", idx), addr_bad, 0);
        check($sformatf("v%0d_rvalid_cycle", idx), rv_k, v.rv_k);
        check($sformatf("v%0d_rvalid_count", idx), rv_n, v.we ? 0 : 1);
        check($sformatf("v%0d_busy_cycles", idx), busy_n, v.busy_n);
        check($sformatf("v%0d_non_owner_quiet", idx), other, 0);
        if (!v.we) begin
            check($sformatf("v%0d_rdata", idx), int'(got), int'(v.rdv));
            if (v.dma) sh_dma = v.rdv; else sh_cpu = v.rdv;
        end
        check($sformatf("v%0d_cpu_rdata_held", idx), int'(ifc.cpu_rdata), int'(sh_cpu));
        check($sformatf("v%0d_dma_rdata_held", idx), int'(ifc.dma_rdata), int'(sh_dma));
    endtask

    initial begin
        logic [7:0] gseq, gmask, rvmask;
        int ev;

        //        dma   we    addr        wdata  rdv    strb ce_n cer_n rv busy
        vt[0] = '{1'b0, 1'b0, 21'h000010, 8'h00, 8'hA5, 1, 1'b0, 1'b1, 3, 2};
        vt[1] = '{1'b1, 1'b1, 21'h1F0004, 8'h3C, 8'h00, 1, 1'b1, 1'b0, 0, 1};
        vt[2] = '{1'b0, 1'b0, 21'h1FE000, 8'h00, 8'h77, 3, 1'b1, 1'b1, 5, 4};
        vt[3] = '{1'b1, 1'b0, 21'h1F7FFF, 8'h00, 8'hC3, 1, 1'b1, 1'b0, 3, 2};
        vt[4] = '{1'b0, 1'b1, 21'h1EFFFF, 8'h99, 8'h00, 1, 1'b0, 1'b1, 0, 1};
        vt[5] = '{1'b1, 1'b1, 21'h1FDFFF, 8'h12, 8'h00, 1, 1'b1, 1'b1, 0, 1};
        vt[6] = '{1'b1, 1'b0, 21'h1FFFFF, 8'h00, 8'h5E, 3, 1'b1, 1'b1, 5, 4};
        vt[7] = '{1'b0, 1'b1, 21'h1F8000, 8'h44, 8'h00, 1, 1'b1, 1'b1, 0, 1};

        ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b0; ifc.cpu_addr = 21'h10; ifc.cpu_wdata = 8'h00;
        ifc.dma_req = 1'b0; ifc.dma_we = 1'b0; ifc.dma_addr = 21'h0;  ifc.dma_wdata = 8'h00;

        // reset state, with a request pending that must be ignored
        repeat (3) @(negedge clk);
        check("rst_ctrl", int'({ifc.busy, ifc.cpu_gnt, ifc.dma_gnt, ifc.cpu_rvalid, ifc.dma_rvalid,
                                ifc.mem_re, ifc.mem_we, ifc.mem_CE_n, ifc.mem_CER_n}), 'b000000011);
        check("rst_mem_addr", int'(ifc.mem_addr), 0);
        check("rst_mem_dIn", int'(ifc.mem_dIn), 0);
        check("rst_rdata", int'({ifc.cpu_rdata, ifc.dma_rdata}), 0);
        ifc.cpu_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // both requesters held across four write transactions
        ifc.cpu_we = 1'b1; ifc.dma_we = 1'b1; ifc.cpu_addr = 21'h100; ifc.dma_addr = 21'h200;
        ifc.cpu_req = 1'b1; ifc.dma_req = 1'b1;
        gseq = 8'h00; gmask = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ifc.cpu_gnt) begin gseq = {gseq[5:0], 2'b01}; gmask[k-1] = 1'b1; end
            if (ifc.dma_gnt) begin gseq = {gseq[5:0], 2'b10}; gmask[k-1] = 1'b1; end
        end
        ifc.cpu_req = 1'b0; ifc.dma_req = 1'b0;
`ifdef ARB_ROUNDROBIN_EN
        check("tie_grant_order", int'(gseq), 'h66);
`else
        check("tie_grant_order", int'(gseq), 'h55);
`endif
        check("tie_grant_cycles", int'(gmask), 'h55);
        repeat (2) @(negedge clk);
        check("tie_idle_after", int'(ifc.busy), 0);

        // CPU read request held: next grant three cycles after the previous one
        ifc.cpu_we = 1'b0; ifc.cpu_addr = 21'h000020; rd_val = 8'h5A; ifc.cpu_req = 1'b1;
        gmask = 8'h00; rvmask = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            gmask[k-1]  = ifc.cpu_gnt;
            rvmask[k-1] = ifc.cpu_rvalid;
            if (k == 7) ifc.cpu_req = 1'b0;
        end
        check("b2b_read_gnt_cycles", int'(gmask), 'h49);
        check("b2b_read_rvalid_cycles", int'(rvmask), 'h24);
        repeat (3) @(negedge clk);
        check("b2b_read_rdata", int'(ifc.cpu_rdata), 'h5A);
        sh_cpu = 8'h5A;

        // request pulse that misses every rising edge
        ifc.cpu_req = 1'b1;
        #2 ifc.cpu_req = 1'b0;
        ev = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (ifc.busy || ifc.cpu_gnt || ifc.mem_re || ifc.mem_we) ev++;
        end
        check("short_req_no_access", ev, 0);

        // reset during the ACCESS cycle of a read
        rd_val = 8'h11; ifc.cpu_addr = 21'h000030; ifc.cpu_req = 1'b1;
        @(negedge clk);
        check("abort_strobe_before", int'(ifc.mem_re), 1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", int'({ifc.mem_re, ifc.mem_we, ifc.busy, ifc.cpu_gnt,
                                     ifc.mem_CE_n, ifc.mem_CER_n}), 'b000011);
        check("abort_rdata_cleared", int'(ifc.cpu_rdata), 0);
        ifc.cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ev = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ifc.busy || ifc.cpu_gnt || ifc.cpu_rvalid || ifc.mem_re || ifc.mem_we) ev++;
        end
        check("abort_no_activity", ev, 0);
        sh_cpu = 8'h00; sh_dma = 8'h00;

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
